// File: rtl/ship_renderer.sv
// Ship sprite renderer: erases the old ship box and draws the new one.
// Optional SHIP_SPRITE_ROM_EN selects a sprite ROM with transparency.
module ship_renderer #(
  parameter int          SHIP_W      = 8,
  parameter int          SHIP_H      = 4,
  parameter int          SHIP_Y      = 112,
  parameter logic [2:0]  SHIP_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] x_val,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    DRAW,
    FINISH
  } state_t;

  localparam logic [7:0] X_MAX  = 8'(160 - SHIP_W);
  localparam logic [4:0] C_LAST = 5'(SHIP_W - 1);
  localparam logic [3:0] R_LAST = 4'(SHIP_H - 1);
  localparam logic [6:0] Y_TOP  = 7'(SHIP_Y);

  state_t     state_q, state_d;
  logic [4:0] c_q, c_d;
  logic [3:0] r_q, r_d;
  logic [7:0] new_x_q, new_x_d;
  logic [7:0] drawn_x_q, drawn_x_d;
  logic       drawn_valid_q, drawn_valid_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] x_c;
  logic [7:0] scan_base;
  logic [2:0] draw_col;

`ifdef SHIP_SPRITE_ROM_EN
  // Sprite pattern: transparent top corners, tinted bottom row.
  function automatic logic [2:0] rom_px(
    input logic [3:0] r,
    input logic [4:0] c
  );
    logic [2:0] px;
    px = SHIP_COLOUR;
    if (r == 4'd0 && (c == 5'd0 || c == C_LAST))
      px = 3'b000;
    else if (r == R_LAST)
      px = 3'b100;
    return px;
  endfunction
`endif

  // Clamp requested x so the sprite never crosses the right edge.
  always_comb begin
    x_c = (x_val > X_MAX) ? X_MAX : x_val;
  end

  // Next-state, scan counters and drawn-position bookkeeping.
  always_comb begin
    state_d       = state_q;
    c_d           = c_q;
    r_d           = r_q;
    new_x_d       = new_x_q;
    drawn_x_d     = drawn_x_q;
    drawn_valid_d = drawn_valid_q;
    unique case (state_q)
      IDLE: begin
        if (frame_tick) begin
          new_x_d = x_c;
          c_d     = 5'd0;
          r_d     = 4'd0;
          if (!drawn_valid_q)
            state_d = DRAW;
          else if (x_c != drawn_x_q)
            state_d = ERASE;
        end
      end
      ERASE, DRAW: begin
        if (c_q == C_LAST) begin
          c_d = 5'd0;
          if (r_q == R_LAST) begin
            r_d     = 4'd0;
            state_d = (state_q == ERASE) ? DRAW : FINISH;
          end else begin
            r_d = r_q + 4'd1;
          end
        end else begin
          c_d = c_q + 5'd1;
        end
      end
      FINISH: begin
        drawn_x_d     = new_x_q;
        drawn_valid_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered adapter outputs for the pixel the next state presents.
  always_comb begin
    scan_base = (state_d == ERASE) ? drawn_x_q : new_x_d;
`ifdef SHIP_SPRITE_ROM_EN
    draw_col  = rom_px(r_d, c_d);
`else
    draw_col  = SHIP_COLOUR;
`endif
    vga_x_d  = vga_x_q;
    vga_y_d  = vga_y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == FINISH);
    if (state_d == ERASE) begin
      plot_d   = 1'b1;
      colour_d = BG_COLOUR;
    end else if (state_d == DRAW) begin
      plot_d   = (draw_col != 3'b000);
      colour_d = plot_d ? draw_col : colour_q;
    end
    if (plot_d) begin
      vga_x_d = scan_base + {3'b000, c_d};
      vga_y_d = Y_TOP + {3'b000, r_d};
    end
  end

  // State and output registers; reset aborts any pass in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      c_q           <= 5'd0;
      r_q           <= 4'd0;
      new_x_q       <= 8'd0;
      drawn_x_q     <= 8'd0;
      drawn_valid_q <= 1'b0;
      vga_x_q       <= 8'd0;
      vga_y_q       <= 7'd0;
      colour_q      <= 3'd0;
      plot_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      c_q           <= c_d;
      r_q           <= r_d;
      new_x_q       <= new_x_d;
      drawn_x_q     <= drawn_x_d;
      drawn_valid_q <= drawn_valid_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      colour_q      <= colour_d;
      plot_q        <= plot_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign vga_x  = vga_x_q;
  assign vga_y  = vga_y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ship_renderer.sv
// Scoreboard bench for ship_renderer.
// Expected pixels queued at tick time, popped on each plot.
module tb_ship_renderer;

  localparam int W = 8;
  localparam int H = 4;
  localparam int Y = 112;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] x_val = 8'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  ship_renderer dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .x_val      (x_val),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #10 clock = ~clock;

  int vecs = 0;
  int errs = 0;
  int plots = 0;
  logic [17:0] exp_q[$];

  logic       m_valid = 1'b0;
  logic [7:0] m_x = 8'd0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] draw_px(input int r, input int c);
`ifdef SHIP_SPRITE_ROM_EN
    if (r == 0 && (c == 0 || c == W - 1)) return 3'b000;
    if (r == H - 1) return 3'b100;
    return 3'b111;
`else
    return 3'b111;
`endif
  endfunction

  // Checks every plotted pixel against the scoreboard head.
  always @(negedge clock) begin
    if (reset && plot) begin
      plots++;
      chk("vga_x_range", 32'(vga_x < 8'd160), 1);
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0)
        chk("pixel", {vga_x, vga_y, colour}, exp_q.pop_front());
    end
  end

  function automatic logic [7:0] clampx(input logic [7:0] x);
    return (x > 8'(160 - W)) ? 8'(160 - W) : x;
  endfunction

  // Queues the expected pixels for a pass; returns scan cycle count.
  task automatic push_pass(input logic [7:0] xc, output int scans);
    scans = 0;
    if (m_valid) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          exp_q.push_back({8'(m_x + c), 7'(Y + r), 3'b000});
          scans++;
        end
    end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (draw_px(r, c) != 3'b000)
          exp_q.push_back({8'(xc + c), 7'(Y + r), draw_px(r, c)});
        scans++;
      end
  endtask

  task automatic tick(input logic [7:0] x);
    @(posedge clock);
    #1;
    frame_tick = 1'b1;
    x_val = x;
    @(posedge clock);
    #1;
    frame_tick = 1'b0;
  endtask

  // One render pass; disturb pokes tick and x_val mid-pass.
  task automatic run_pass(input string tag,
                          input logic [7:0] x,
                          input bit disturb);
    logic [7:0] xc;
    int scans;
    int n;
    bit sawb;
    bit sawd;
    int p0;
    xc = clampx(x);
    if (m_valid && xc == m_x) begin
      p0 = plots;
      sawb = 0;
      sawd = 0;
      tick(x);
      for (int i = 0; i < 40; i++) begin
        @(negedge clock);
        if (busy) sawb = 1;
        if (done) sawd = 1;
      end
      chk({tag, "_noop_busy"}, 32'(sawb), 0);
      chk({tag, "_noop_done"}, 32'(sawd), 0);
      chk({tag, "_noop_plot"}, plots - p0, 0);
      return;
    end
    push_pass(xc, scans);
    tick(x);
    n = 0;
    while (n < 300) begin
      @(negedge clock);
      n++;
      if (n == 1) chk({tag, "_busy_rise"}, 32'(busy), 1);
      if (disturb && n == 5) begin
        frame_tick = 1'b1;
        x_val = x + 8'd3;
      end
      if (disturb && n == 6) frame_tick = 1'b0;
      if (done) break;
    end
    chk({tag, "_done_lat"}, n, scans + 1);
    chk({tag, "_sb_drained"}, exp_q.size(), 0);
    @(negedge clock);
    chk({tag, "_busy_fall"}, 32'(busy), 0);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    m_valid = 1'b1;
    m_x = xc;
  endtask

  initial begin
    int scans;
    #5;
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    run_pass("first", 8'd10, 0);
    run_pass("move", 8'd11, 0);
    run_pass("same", 8'd11, 0);
    run_pass("clamp", 8'd255, 0);
    run_pass("edge", 8'd152, 0);
    run_pass("disturb", 8'd60, 1);
    run_pass("after_dist", 8'd63, 0);

    push_pass(clampx(8'd100), scans);
    tick(8'd100);
    repeat (W * H + 10) @(negedge clock);
    chk("mid_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("abort_plot", 32'(plot), 0);
    chk("abort_busy", 32'(busy), 0);
    exp_q.delete();
    m_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_pass("post_rst", 8'd40, 0);
    run_pass("zero", 8'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
